// File: rtl/rvee_rf_arb.sv
`default_nettype none
// ============================================================================
// Module   : rvee_rf_arb
// Brief    : Register-file access controller for the RVee core. Zero-fills
//            x1..x(N_REGS-1) after reset, passes pipeline writeback and rs1
//            reads through, and grants a debug requester exclusive
//            single-register access by stalling the pipeline around it.
// Revision : 1.0 - initial release
// ============================================================================
module rvee_rf_arb #(
  parameter int XLEN    = 32,
  parameter int N_REGS  = 32,
  parameter int DBG_GAP = 4,
  localparam int AW     = $clog2(N_REGS)
) (
  input  logic            clk,
  input  logic            rst,

  // pipeline writeback request
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,

  // pipeline rs1 read
  input  logic [AW-1:0]   pipe_rs1_i,
  output logic [XLEN-1:0] pipe_rs1_data_o,
  output logic            pipe_stall_o,

  // register-file ports
  output logic            rf_wb_we_o,
  output logic [AW-1:0]   rf_wb_rd_o,
  output logic [XLEN-1:0] rf_wb_data_o,
  output logic [AW-1:0]   rf_rs1_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  output logic            rf_fw_block_o,

  // debug request channel
  input  logic            dbg_req_valid_i,
  input  logic            dbg_req_we_i,
  input  logic [AW-1:0]   dbg_req_addr_i,
  input  logic [XLEN-1:0] dbg_req_wdata_i,
  output logic            dbg_req_ready_o,

  // debug response channel
  output logic            dbg_rsp_valid_o,
  output logic [XLEN-1:0] dbg_rsp_rdata_o,
  input  logic            dbg_rsp_ready_i
);

  // Gap counter must hold DBG_GAP; keep at least one bit when DBG_GAP is 0.
  localparam int GW = (DBG_GAP > 0) ? $clog2(DBG_GAP + 1) : 1;

  localparam logic [AW-1:0] c_last_reg = AW'(N_REGS - 1);
  localparam logic [GW-1:0] c_gap_load = GW'(DBG_GAP);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_STALL  = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap;
  logic [XLEN-1:0] r_rsp_rdata;

  state_t          w_state_nxt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [GW-1:0]   w_gap_nxt;
  logic [XLEN-1:0] w_rsp_rdata_nxt;

  logic            w_wb_we;
  logic [AW-1:0]   w_wb_rd;
  logic [XLEN-1:0] w_wb_data;
  logic [AW-1:0]   w_rs1;
  logic            w_stall;
  logic            w_fw_block;
  logic            w_req_ready;
  logic            w_rsp_valid;

  // State, counters and captured debug read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= AW'(1);
      r_gap       <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Next-state logic and per-state register-file port steering.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gap_nxt       = r_gap;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_wb_we         = 1'b0;
    w_wb_rd         = '0;
    w_wb_data       = '0;
    w_rs1           = pipe_rs1_i;
    w_stall         = 1'b1;
    w_fw_block      = 1'b0;
    w_req_ready     = 1'b0;
    w_rsp_valid     = 1'b0;

    case (r_state)
      S_INIT: begin
        // The register file has no reset: walk x1..x(N_REGS-1) writing zero.
        w_wb_we   = 1'b1;
        w_wb_rd   = r_cnt;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == c_last_reg) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_IDLE: begin
        w_wb_we   = wb_we_i;
        w_wb_rd   = wb_rd_i;
        w_wb_data = wb_data_i;
        w_stall   = 1'b0;
        if (r_gap != '0) begin
          // Debug requests are ignored until the gap has drained.
          w_gap_nxt = r_gap - GW'(1);
        end else if (dbg_req_valid_i) begin
          w_state_nxt = S_STALL;
        end
      end

      S_STALL: begin
        // Let the instruction already in WB retire while the front freezes.
        w_wb_we     = wb_we_i;
        w_wb_rd     = wb_rd_i;
        w_wb_data   = wb_data_i;
        w_state_nxt = S_ACCESS;
      end

      S_ACCESS: begin
        // Debug owns both ports; forwarding makes a write read back its data.
        w_fw_block      = 1'b1;
        w_req_ready     = 1'b1;
        w_rs1           = dbg_req_addr_i;
        w_wb_we         = dbg_req_we_i && (dbg_req_addr_i != '0);
        w_wb_rd         = dbg_req_addr_i;
        w_wb_data       = dbg_req_wdata_i;
        w_rsp_rdata_nxt = rf_rs1_data_i;
        w_state_nxt     = S_RESP;
      end

      S_RESP: begin
        // WB only carries bubbles here, so passing it through is harmless.
        w_wb_we     = wb_we_i;
        w_wb_rd     = wb_rd_i;
        w_wb_data   = wb_data_i;
        w_rsp_valid = 1'b1;
        if (dbg_rsp_ready_i) begin
          w_gap_nxt   = c_gap_load;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // While reset is held every output is forced quiet except the stall.
  assign pipe_rs1_data_o = rf_rs1_data_i;
  assign pipe_stall_o    = rst | w_stall;
  assign rf_wb_we_o      = ~rst & w_wb_we;
  assign rf_wb_rd_o      = rst ? '0 : w_wb_rd;
  assign rf_wb_data_o    = rst ? '0 : w_wb_data;
  assign rf_rs1_o        = rst ? '0 : w_rs1;
  assign rf_fw_block_o   = ~rst & w_fw_block;
  assign dbg_req_ready_o = ~rst & w_req_ready;
  assign dbg_rsp_valid_o = ~rst & w_rsp_valid;
  assign dbg_rsp_rdata_o = rst ? '0 : r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rvee_rf_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvee_rf_arb
// Brief    : Self-checking bench for rvee_rf_arb with a behavioural register
//            file (same-cycle forwarding) and a debug-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvee_rf_arb;

  localparam int XLEN    = 32;
  localparam int N_REGS  = 32;
  localparam int AW      = 5;
  localparam int DBG_GAP = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wb_we_i;
  logic [AW-1:0]   wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic [AW-1:0]   pipe_rs1_i;
  logic [XLEN-1:0] pipe_rs1_data_o;
  logic            pipe_stall_o;
  logic            rf_wb_we_o;
  logic [AW-1:0]   rf_wb_rd_o;
  logic [XLEN-1:0] rf_wb_data_o;
  logic [AW-1:0]   rf_rs1_o;
  logic [XLEN-1:0] rf_rs1_data_i;
  logic            rf_fw_block_o;
  logic            dbg_req_valid_i;
  logic            dbg_req_we_i;
  logic [AW-1:0]   dbg_req_addr_i;
  logic [XLEN-1:0] dbg_req_wdata_i;
  logic            dbg_req_ready_o;
  logic            dbg_rsp_valid_o;
  logic [XLEN-1:0] dbg_rsp_rdata_o;
  logic            dbg_rsp_ready_i;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN-1:0] q_exp [$];
  logic [XLEN-1:0] r_regs [N_REGS];

  always #5 clk = ~clk;

  rvee_rf_arb #(
    .XLEN    (XLEN),
    .N_REGS  (N_REGS),
    .DBG_GAP (DBG_GAP)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .wb_we_i         (wb_we_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .pipe_rs1_i      (pipe_rs1_i),
    .pipe_rs1_data_o (pipe_rs1_data_o),
    .pipe_stall_o    (pipe_stall_o),
    .rf_wb_we_o      (rf_wb_we_o),
    .rf_wb_rd_o      (rf_wb_rd_o),
    .rf_wb_data_o    (rf_wb_data_o),
    .rf_rs1_o        (rf_rs1_o),
    .rf_rs1_data_i   (rf_rs1_data_i),
    .rf_fw_block_o   (rf_fw_block_o),
    .dbg_req_valid_i (dbg_req_valid_i),
    .dbg_req_we_i    (dbg_req_we_i),
    .dbg_req_addr_i  (dbg_req_addr_i),
    .dbg_req_wdata_i (dbg_req_wdata_i),
    .dbg_req_ready_o (dbg_req_ready_o),
    .dbg_rsp_valid_o (dbg_rsp_valid_o),
    .dbg_rsp_rdata_o (dbg_rsp_rdata_o),
    .dbg_rsp_ready_i (dbg_rsp_ready_i)
  );

  // Register file storage: written through the DUT's write port.
  always_ff @(posedge clk) begin
    if (rf_wb_we_o && (rf_wb_rd_o != '0)) begin
      r_regs[rf_wb_rd_o] <= rf_wb_data_o;
    end
  end

  // Read port with x0 hardwired to zero and same-cycle write forwarding.
  always_comb begin
    if (rf_rs1_o == '0) begin
      rf_rs1_data_i = '0;
    end else if (rf_wb_we_o && (rf_wb_rd_o == rf_rs1_o)) begin
      rf_rs1_data_i = rf_wb_data_o;
    end else begin
      rf_rs1_data_i = r_regs[rf_rs1_o];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Debug responses are scored at every completed response handshake.
  always @(negedge clk) begin
    if (!rst && dbg_rsp_valid_o && dbg_rsp_ready_i) begin
      chk("rsp_pending", 64'(q_exp.size() > 0), 64'd1);
      if (q_exp.size() > 0) begin
        chk("rsp_rdata", 64'(dbg_rsp_rdata_o), 64'(q_exp.pop_front()));
      end
    end
  end

  task automatic zfill_check();
    for (int i = 1; i < N_REGS; i++) begin
      #3;
      chk("zf_we", 64'(rf_wb_we_o), 64'd1);
      chk("zf_rd", 64'(rf_wb_rd_o), 64'(i));
      chk("zf_data", 64'(rf_wb_data_o), 64'd0);
      chk("zf_stall", 64'(pipe_stall_o), 64'd1);
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #3;
      chk("idle_stall", 64'(pipe_stall_o), 64'd0);
      chk("idle_rsp_valid", 64'(dbg_rsp_valid_o), 64'd0);
      step();
    end
  endtask

  task automatic dbg_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] exp_rdata,
                         input int n_idle, input int hold, input bit wb_coll);
    dbg_req_valid_i = 1'b1;
    dbg_req_we_i    = we;
    dbg_req_addr_i  = addr;
    dbg_req_wdata_i = wdata;
    q_exp.push_back(exp_rdata);
    if (wb_coll) begin
      wb_we_i   = 1'b1;
      wb_rd_i   = AW'(9);
      wb_data_i = 32'h11;
    end
    for (int i = 0; i < n_idle; i++) begin
      #3;
      chk("req_idle_stall", 64'(pipe_stall_o), 64'd0);
      chk("req_idle_ready", 64'(dbg_req_ready_o), 64'd0);
      if (wb_coll) begin
        chk("coll_idle_we", 64'(rf_wb_we_o), 64'd1);
        chk("coll_idle_data", 64'(rf_wb_data_o), 64'h11);
      end
      step();
    end
    #3;
    chk("stall_stall", 64'(pipe_stall_o), 64'd1);
    chk("stall_ready", 64'(dbg_req_ready_o), 64'd0);
    chk("stall_fw", 64'(rf_fw_block_o), 64'd0);
    if (wb_coll) begin
      chk("coll_stall_we", 64'(rf_wb_we_o), 64'd1);
      chk("coll_stall_rd", 64'(rf_wb_rd_o), 64'd9);
      chk("coll_stall_data", 64'(rf_wb_data_o), 64'h11);
    end
    step();
    if (wb_coll) wb_data_i = 32'h22;
    #3;
    chk("acc_ready", 64'(dbg_req_ready_o), 64'd1);
    chk("acc_stall", 64'(pipe_stall_o), 64'd1);
    chk("acc_fw", 64'(rf_fw_block_o), 64'd1);
    chk("acc_rs1", 64'(rf_rs1_o), 64'(addr));
    chk("acc_we", 64'(rf_wb_we_o), 64'(we && (addr != '0)));
    if (we && (addr != '0)) begin
      chk("acc_rd", 64'(rf_wb_rd_o), 64'(addr));
      chk("acc_data", 64'(rf_wb_data_o), 64'(wdata));
    end
    chk("acc_rsp_valid", 64'(dbg_rsp_valid_o), 64'd0);
    step();
    dbg_req_valid_i = 1'b0;
    wb_we_i         = 1'b0;
    dbg_rsp_ready_i = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      #3;
      chk("bp_rsp_valid", 64'(dbg_rsp_valid_o), 64'd1);
      chk("bp_stall", 64'(pipe_stall_o), 64'd1);
      step();
    end
    dbg_rsp_ready_i = 1'b1;
    #3;
    chk("resp_valid", 64'(dbg_rsp_valid_o), 64'd1);
    chk("resp_stall", 64'(pipe_stall_o), 64'd1);
    step();
  endtask

  // Hard bound on simulated time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_we_i         = 1'b0;
    wb_rd_i         = '0;
    wb_data_i       = '0;
    pipe_rs1_i      = '0;
    dbg_req_valid_i = 1'b0;
    dbg_req_we_i    = 1'b0;
    dbg_req_addr_i  = '0;
    dbg_req_wdata_i = '0;
    dbg_rsp_ready_i = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_we", 64'(rf_wb_we_o), 64'd0);
    chk("rst_rd", 64'(rf_wb_rd_o), 64'd0);
    chk("rst_stall", 64'(pipe_stall_o), 64'd1);
    chk("rst_ready", 64'(dbg_req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(dbg_rsp_valid_o), 64'd0);
    chk("rst_rdata", 64'(dbg_rsp_rdata_o), 64'd0);
    chk("rst_fw", 64'(rf_fw_block_o), 64'd0);
    step();

    // Zero-fill with a pipeline write pending that must be ignored.
    rst        = 1'b0;
    wb_we_i    = 1'b1;
    wb_rd_i    = AW'(5);
    wb_data_i  = 32'hDEADBEEF;
    pipe_rs1_i = AW'(4);
    zfill_check();

    // First IDLE cycle: passthrough, x4 reads back zero.
    #3;
    chk("idle0_stall", 64'(pipe_stall_o), 64'd0);
    chk("idle0_we", 64'(rf_wb_we_o), 64'd1);
    chk("idle0_rd", 64'(rf_wb_rd_o), 64'd5);
    chk("idle0_data", 64'(rf_wb_data_o), 64'hDEADBEEF);
    chk("idle0_rs1", 64'(rf_rs1_o), 64'd4);
    chk("idle0_rs1_data", 64'(pipe_rs1_data_o), 64'd0);
    step();
    wb_rd_i   = AW'(7);
    wb_data_i = 32'h12345678;
    #3;
    chk("preload_we", 64'(rf_wb_we_o), 64'd1);
    step();
    wb_we_i = 1'b0;

    // Read, write, x0 write, read-back.
    dbg_txn(1'b0, AW'(7), 32'h0, 32'h12345678, 1, 0, 1'b0);
    idle(6);
    dbg_txn(1'b1, AW'(3), 32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 1'b0);
    idle(6);
    dbg_txn(1'b1, AW'(0), 32'hFFFFFFFF, 32'h0, 1, 0, 1'b0);
    idle(6);
    dbg_txn(1'b0, AW'(3), 32'h0, 32'hCAFEF00D, 1, 0, 1'b0);
    idle(6);

    // Back-pressure, then a back-to-back request held off by the gap.
    dbg_txn(1'b0, AW'(5), 32'h0, 32'hDEADBEEF, 1, 5, 1'b0);
    dbg_txn(1'b0, AW'(7), 32'h0, 32'h12345678, DBG_GAP + 1, 0, 1'b0);
    idle(6);

    // Writeback collision around a debug read of x9.
    dbg_txn(1'b0, AW'(9), 32'h0, 32'h11, 1, 0, 1'b1);
    idle(6);

    // Reset during RESP: response lost, zero-fill restarts.
    dbg_req_valid_i = 1'b1;
    dbg_req_we_i    = 1'b0;
    dbg_req_addr_i  = AW'(7);
    step();
    step();
    step();
    dbg_req_valid_i = 1'b0;
    dbg_rsp_ready_i = 1'b0;
    #1;
    chk("mid_rsp_valid", 64'(dbg_rsp_valid_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 64'(dbg_rsp_valid_o), 64'd0);
    chk("mid_rst_stall", 64'(pipe_stall_o), 64'd1);
    chk("mid_rst_we", 64'(rf_wb_we_o), 64'd0);
    step();
    rst = 1'b0;
    zfill_check();
    idle(1);
    dbg_txn(1'b0, AW'(7), 32'h0, 32'h0, 1, 0, 1'b0);
    idle(2);

    chk("sb_empty", 64'(q_exp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rvee_rf_arb.md
# rvee_rf_arb

Register-file access controller sitting between the RVee pipeline, a debug requester and the register file. After reset it sequences a zero-fill of x1..x(N_REGS-1), because the register file itself has no reset. In normal operation it passes pipeline writeback and rs1 reads straight through. It grants the debug requester exclusive single-register read/write access by stalling the pipeline around each transaction, with a guaranteed minimum gap between debug accesses.

## Interface
Parameters:
- XLEN, 32, register width.
- N_REGS, 32, register count (16 or 32, power of two); AW = $clog2(N_REGS).
- DBG_GAP, 4, IDLE cycles after each debug response during which debug requests are ignored (0 allowed).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- wb_we_i, wb_rd_i[AW], wb_data_i[XLEN]  in  pipeline writeback request.
- pipe_rs1_i  in  AW  pipeline rs1 index.
- pipe_rs1_data_o  out  XLEN  rs1 data to the pipeline (= rf_rs1_data_i, combinational).
- pipe_stall_o  out  1  freeze pipeline stages before WB.
- rf_wb_we_o, rf_wb_rd_o[AW], rf_wb_data_o[XLEN]  out  register-file write port.
- rf_rs1_o  out  AW  register-file rs1 index.
- rf_rs1_data_i  in  XLEN  register-file rs1 data, including forwarding.
- rf_fw_block_o  out  1  core gates MEM-stage forwarding while this is high.
- dbg_req_valid_i, dbg_req_we_i, dbg_req_addr_i[AW], dbg_req_wdata_i[XLEN]  in  debug request.
- dbg_req_ready_o  out  1  request accepted.
- dbg_rsp_valid_o  out  1  response valid.
- dbg_rsp_rdata_o  out  XLEN  response data.
- dbg_rsp_ready_i  in  1  response consumed.

## Operation
- States: INIT, IDLE, STALL, ACCESS, RESP. Registered: state, init counter cnt[AW], gap counter gap, dbg_rsp_rdata.
- Reset (async): state=INIT, cnt=1, gap=0, dbg_rsp_rdata=0. While rst is high, all outputs are 0 except pipe_stall_o=1 and pipe_rs1_data_o.
- INIT:
  - rf_wb_we_o=1, rf_wb_rd_o=cnt, rf_wb_data_o=0, pipe_stall_o=1; wb_we_i is ignored.
  - cnt increments each cycle. After the cycle with cnt=N_REGS-1, go to IDLE.
- IDLE:
  - rf_wb_* = wb_*_i; rf_rs1_o = pipe_rs1_i; pipe_stall_o=0.
  - If gap>0, gap decrements and dbg_req_valid_i is ignored.
  - Otherwise, if dbg_req_valid_i=1, go to STALL.
- STALL (1 cycle):
  - pipe_stall_o=1; writeback still passes through so the retiring WB instruction completes.
  - Pipeline contract: the cycle after pipe_stall_o rises, WB presents a bubble (wb_we_i=0).
  - Go to ACCESS.
- ACCESS (1 cycle):
  - pipe_stall_o=1, rf_fw_block_o=1, dbg_req_ready_o=1, rf_rs1_o=dbg_req_addr_i.
  - rf_wb_we_o=dbg_req_we_i && addr!=0, rf_wb_rd_o=addr, rf_wb_data_o=dbg_req_wdata_i.
  - wb_we_i is ignored.
  - Capture dbg_rsp_rdata<=rf_rs1_data_i. Because of same-cycle forwarding, a write returns its wdata, and x0 always returns 0.
  - Go to RESP.
- RESP:
  - pipe_stall_o=1, dbg_rsp_valid_o=1.
  - Hold until dbg_rsp_ready_i=1, then go to IDLE with gap=DBG_GAP.
- Requester rule: dbg_req_* must stay stable from valid assertion until ready. Valid may not drop before ready.
- Reset asserted in any state aborts the transaction: the response is lost and INIT restarts (full zero-fill).

## Timing
- Zero-fill takes N_REGS-1 cycles. With reset released before edge 0, x1..x31 are written on edges 0..30, and the first IDLE cycle is cycle 31 (N_REGS=32).
- Debug latency: valid seen in IDLE at cycle t, STALL at t+1, ACCESS/ready at t+2, rsp_valid from t+3. Best-case stall is 3 cycles when rsp_ready is already high.
- Between rsp handshake and the next accepted request there are at least DBG_GAP+1 IDLE cycles in which the pipeline runs unstalled.
- All state-derived outputs are combinational from registered state. No combinational path exists from dbg_rsp_ready_i to any output.

## Test plan
- Reset sequence, N_REGS=32: release rst, then check rf_wb_we_o=1 with rd=1..31 and data=0 on consecutive cycles and pipe_stall_o=1 throughout; cycle 31 shows pipe_stall_o=0 and passthrough of wb_we_i=1, rd=5, data=0xDEADBEEF.
- Debug read: x7 holds 0x12345678, dbg read of addr 7 gives STALL, ACCESS (ready=1, rf_rs1_o=7), then RESP with rdata=0x12345678; 3 stall cycles with rsp_ready tied high.
- Debug write: write 0xCAFEF00D to x3 gives rf_wb_we_o=1, rd=3 in ACCESS and rdata=0xCAFEF00D. Writing x0 gives rf_wb_we_o=0 and rdata=0.
- Back-pressure and gap: hold rsp_ready low for 5 cycles, so rsp_valid and pipe_stall stay high for 5 cycles. With a back-to-back request and DBG_GAP=4, check 5 unstalled IDLE cycles before the next STALL.
- WB collision: wb_we_i=1 (rd=9, 0x11) in the IDLE cycle of request arrival and in STALL must be written. wb_we_i=1 forced during ACCESS must not reach rf_wb_*.
- Reset mid-op: assert rst in RESP, then check rsp_valid drops immediately and the zero-fill restarts from x1.
